spi_frame_buffer: RTL and testbench

//  Host-side frame buffer that sits directly upstream of the SPI frame controller.
//  The host loads TX words into a FIFO and issues start.
//  The block then holds spi_en for one frame of FRAME_WORDS words and feeds the

---
 rtl/spi_frame_buffer.sv | 120 ++++++++++++
 tb/tb_spi_frame_buffer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_buffer.sv
// spi_frame_buffer: host TX/RX FIFOs around an SPI frame controller, sequencing one frame per start
module spi_frame_buffer_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && count != FULL;
  assign do_pop = pop && count != '0;
  assign dout = count == '0 ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

module spi_frame_buffer #(
  parameter int DATA_BITS = 8,
  parameter int FRAME_WORDS = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       wr_data,
  output logic                       tx_full,
  output logic [$clog2(DEPTH):0]     tx_count,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       spi_en,
  output logic [DATA_BITS-1:0]       spi_data,
  input  logic                       spi_ready,
  input  logic                       spi_valid,
  input  logic [DATA_BITS-1:0]       spi_rx_data,
  input  logic                       rd_en,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       rx_empty,
  output logic [$clog2(DEPTH):0]     rx_count,
  output logic                       spi_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(FRAME_WORDS) + 1;
  localparam logic [CW-1:0] FW_C = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] RX_LIM = CW'(DEPTH - FRAME_WORDS);
  localparam logic [SW-1:0] FW_S = SW'(FRAME_WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [SW-1:0] sent, rcvd, sent_n, rcvd_n;
  logic tx_pop, rx_push;
  // Pops stop at FRAME_WORDS so host words queued during RUN stay for the next frame
  assign tx_pop = state == RUN && spi_ready && sent != FW_S;
  assign rx_push = state != IDLE && spi_valid && rcvd != FW_S;
  assign sent_n = sent + SW'(tx_pop);
  assign rcvd_n = rcvd + SW'(rx_push);
  assign tx_full = tx_count == FULL_C;
  assign rx_empty = rx_count == '0;
  spi_frame_buffer_fifo #(.W(DATA_BITS), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(wr_en), .pop(tx_pop), .din(wr_data), .dout(spi_data), .count(tx_count)
  );
  spi_frame_buffer_fifo #(.W(DATA_BITS), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rd_en), .din(spi_rx_data), .dout(rd_data), .count(rx_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sent <= '0;
      rcvd <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      spi_en <= 1'b0;
      spi_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (spi_ready || spi_valid) spi_err <= 1'b1;
        if (start && tx_count >= FW_C && rx_count <= RX_LIM) begin
          state <= RUN;
          busy <= 1'b1;
          spi_en <= 1'b1;
          sent <= '0;
          rcvd <= '0;
        end
      end else begin
        sent <= sent_n;
        rcvd <= rcvd_n;
        if (sent_n == FW_S && rcvd_n == FW_S) begin
          state <= IDLE;
          busy <= 1'b0;
          spi_en <= 1'b0;
          done <= 1'b1;
        end else if (state == RUN && sent_n == FW_S) begin
          state <= DRAIN;
          spi_en <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_buffer.sv
// tb_spi_frame_buffer: scoreboard bench driving host and controller sides of spi_frame_buffer
module tb_spi_frame_buffer;
  logic clk = 1'b0;
  logic rst, wr_en, start, spi_ready, spi_valid, rd_en;
  logic [7:0] wr_data, spi_rx_data, spi_data, rd_data;
  logic tx_full, busy, done, spi_en, rx_empty, spi_err;
  logic [3:0] tx_count, rx_count;
  int checks = 0, errors = 0, done_cnt = 0, m_tx = 0, m_rx = 0;
  logic [7:0] txq[$], rxq[$];

  spi_frame_buffer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_count(tx_count),
    .start(start), .busy(busy), .done(done), .spi_en(spi_en), .spi_data(spi_data),
    .spi_ready(spi_ready), .spi_valid(spi_valid), .spi_rx_data(spi_rx_data), .rd_en(rd_en),
    .rd_data(rd_data), .rx_empty(rx_empty), .rx_count(rx_count), .spi_err(spi_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    wr_en = 1'b1;
    wr_data = w;
    if (m_tx < 8) begin
      txq.push_back(w);
      m_tx++;
    end
    step;
    wr_en = 1'b0;
  endtask

  task automatic pop_rx(input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rd_data !== rxq[0]) begin
        errors++;
        $display("FAIL rd_data: got %h expected %h", rd_data, rxq[0]);
      end
      void'(rxq.pop_front());
      m_rx--;
      rd_en = 1'b1;
      step;
      rd_en = 1'b0;
    end
    checks++;
    if (rx_count !== 4'(m_rx)) begin
      errors++;
      $display("FAIL rx_count_after_read: got %0d expected %0d", rx_count, m_rx);
    end
  endtask

  task automatic run_frame(input bit lag, input logic [7:0] base);
    int d0 = done_cnt;
    start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if ({busy, spi_en} !== 2'b11) begin
      errors++;
      $display("FAIL frame_start: got busy,spi_en=%b expected 11", {busy, spi_en});
    end
    for (int i = 0; i < 4 + int'(lag); i++) begin
      if (i < 4) begin
        checks++;
        if (spi_data !== txq[0]) begin
          errors++;
          $display("FAIL spi_data: got %h expected %h", spi_data, txq[0]);
        end
        void'(txq.pop_front());
        m_tx--;
      end
      spi_ready = i < 4;
      spi_valid = i >= int'(lag);
      if (spi_valid) begin
        spi_rx_data = base + 8'(17 * (i - int'(lag)));
        rxq.push_back(spi_rx_data);
        m_rx++;
      end
      step;
      spi_ready = 1'b0;
      spi_valid = 1'b0;
      if (lag && i == 3) begin
        checks++;
        if ({spi_en, busy, done} !== 3'b010) begin
          errors++;
          $display("FAIL drain_state: got spi_en,busy,done=%b expected 010", {spi_en, busy, done});
        end
      end
    end
    checks++;
    if ({done, busy, spi_en} !== 3'b100) begin
      errors++;
      $display("FAIL frame_end: got done,busy,spi_en=%b expected 100", {done, busy, spi_en});
    end
    step;
    checks++;
    if (done !== 1'b0 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL done_pulse: got done=%b pulses=%0d expected done=0 pulses=1", done, done_cnt - d0);
    end
    checks++;
    if (tx_count !== 4'(m_tx) || rx_count !== 4'(m_rx)) begin
      errors++;
      $display("FAIL frame_counts: got tx=%0d rx=%0d expected tx=%0d rx=%0d", tx_count, rx_count, m_tx, m_rx);
    end
  endtask

  task automatic test_reset;
    {wr_en, start, spi_ready, spi_valid, rd_en} = '0;
    wr_data = '0;
    spi_rx_data = '0;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    checks++;
    if ({busy, done, spi_en, spi_err, tx_full, tx_count, rx_count, spi_data, rd_data} !== '0 || rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b en=%b err=%b tx=%0d rx=%0d empty=%b expected zeros empty=1",
               busy, done, spi_en, spi_err, tx_count, rx_count, rx_empty);
    end
  endtask

  task automatic test_frame;
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    push(8'hD4);
    checks++;
    if (tx_count !== 4'd4) begin
      errors++;
      $display("FAIL tx_count_4: got %0d expected 4", tx_count);
    end
    run_frame(1'b1, 8'h11);
    pop_rx(4);
  endtask

  task automatic test_start_guard;
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if ({busy, spi_en} !== 2'b00 || tx_count !== 4'd3) begin
      errors++;
      $display("FAIL short_start: got busy,spi_en=%b tx=%0d expected 00 tx=3", {busy, spi_en}, tx_count);
    end
    push(8'h33);
    run_frame(1'b0, 8'h50);
    pop_rx(4);
  endtask

  task automatic test_tx_full;
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
    checks++;
    if (tx_count !== 4'd8 || tx_full !== 1'b1) begin
      errors++;
      $display("FAIL tx_fill: got tx=%0d full=%b expected 8 1", tx_count, tx_full);
    end
    push(8'hFF);
    checks++;
    if (tx_count !== 4'd8) begin
      errors++;
      $display("FAIL tx_overflow: got %0d expected 8", tx_count);
    end
    wr_en = 1'b1;
    wr_data = 8'hEE;
    spi_ready = 1'b1;
    step;
    wr_en = 1'b0;
    spi_ready = 1'b0;
    checks++;
    if (tx_count !== 4'd8 || spi_err !== 1'b1 || spi_data !== txq[0]) begin
      errors++;
      $display("FAIL full_wr_ready: got tx=%0d err=%b head=%h expected 8 1 %h", tx_count, spi_err, spi_data, txq[0]);
    end
  endtask

  task automatic test_rx_space;
    run_frame(1'b1, 8'h80);
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    run_frame(1'b0, 8'h90);
    pop_rx(3);
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if ({busy, spi_en} !== 2'b00 || rx_count !== 4'd5 || tx_count !== 4'd8) begin
      errors++;
      $display("FAIL rx_space_start: got busy,en=%b rx=%0d tx=%0d expected 00 5 8", {busy, spi_en}, rx_count, tx_count);
    end
    pop_rx(1);
    run_frame(1'b1, 8'hB0);
    pop_rx(8);
    checks++;
    if (rx_empty !== 1'b1) begin
      errors++;
      $display("FAIL rx_empty: got %b expected 1", rx_empty);
    end
  endtask

  task automatic test_abort;
    int d0;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    d0 = done_cnt;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (spi_data !== txq[0]) begin
        errors++;
        $display("FAIL abort_spi_data: got %h expected %h", spi_data, txq[0]);
      end
      void'(txq.pop_front());
      spi_ready = 1'b1;
      step;
      spi_ready = 1'b0;
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    txq.delete();
    rxq.delete();
    m_tx = 0;
    m_rx = 0;
    checks++;
    if ({spi_en, busy, spi_err, tx_count, rx_count, spi_data, rd_data} !== '0) begin
      errors++;
      $display("FAIL abort_state: got en=%b busy=%b err=%b tx=%0d rx=%0d data=%h rd=%h expected zeros",
               spi_en, busy, spi_err, tx_count, rx_count, spi_data, rd_data);
    end
    repeat (10) step;
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_err;
    spi_valid = 1'b1;
    spi_rx_data = 8'h5A;
    step;
    spi_valid = 1'b0;
    checks++;
    if (spi_err !== 1'b1 || rx_count !== 4'd0) begin
      errors++;
      $display("FAIL idle_valid: got err=%b rx=%0d expected 1 0", spi_err, rx_count);
    end
    repeat (5) step;
    checks++;
    if (spi_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", spi_err);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if (spi_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", spi_err);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_start_guard;
    test_tx_full;
    test_rx_space;
    test_abort;
    test_err;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
